// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: synchronises and edge-detects the three buttons,
// sequences IDLE/RUN/PAUSE/LAP, generates the count tick and handles lap freeze.
module stopwatch_ctrl #(
  parameter int DIV = 1000000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        btn_ss,
  input  logic        btn_lap,
  input  logic        btn_rst,
  input  logic [23:0] t_in,
  output logic        tick,
  output logic        cnt_clr,
  output logic [23:0] t_disp,
  output logic [1:0]  state,
  output logic        running
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] LAP   = 2'b11;

  localparam logic [19:0] PRESC_LAST = 20'(DIV - 1);

  // Bits [1:0] are the synchroniser pair, bit [2] remembers the previous level
  logic [2:0] ss_sync;
  logic [2:0] lap_sync;
  logic [2:0] rst_sync;
  logic       ss_p;
  logic       lap_p;
  logic       rst_p;

  logic [1:0]  next_state;
  logic        take_rst;
  logic [19:0] presc;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ss_sync  <= 3'b000;
      lap_sync <= 3'b000;
      rst_sync <= 3'b000;
    end else begin
      ss_sync  <= {ss_sync[1:0], btn_ss};
      lap_sync <= {lap_sync[1:0], btn_lap};
      rst_sync <= {rst_sync[1:0], btn_rst};
    end
  end

  assign ss_p  = ss_sync[1]  & ~ss_sync[2];
  assign lap_p = lap_sync[1] & ~lap_sync[2];
  assign rst_p = rst_sync[1] & ~rst_sync[2];

  // Priority rst > ss > lap, but an event illegal in the current state
  // steps aside so the next legal one can act.
  always_comb begin
    next_state = state;
    take_rst   = 1'b0;
    if (rst_p && (state == IDLE || state == PAUSE)) begin
      next_state = IDLE;
      take_rst   = 1'b1;
    end else if (ss_p) begin
      next_state = (state == RUN || state == LAP) ? PAUSE : RUN;
    end else if (lap_p && state == RUN) begin
      next_state = LAP;
    end else if (lap_p && state == LAP) begin
      next_state = RUN;
    end
  end

  assign running = state[0];

  // The prescaler only advances on edges where the block stays running, so
  // tick can never land in IDLE/PAUSE and a paused phase is kept intact.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      presc   <= 20'd0;
      tick    <= 1'b0;
      cnt_clr <= 1'b0;
    end else begin
      state   <= next_state;
      cnt_clr <= take_rst;
      tick    <= 1'b0;
      if (take_rst) begin
        presc <= 20'd0;
      end else if (state[0] && next_state[0]) begin
        if (presc == PRESC_LAST) begin
          presc <= 20'd0;
          tick  <= 1'b1;
        end else begin
          presc <= presc + 20'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      t_disp <= 24'd0;
    end else if (state != LAP) begin
      t_disp <= t_in;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (DIV=4): directed scenarios followed by random
// button/time traffic, all compared each cycle against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        btn_ss = 1'b0;
  logic        btn_lap = 1'b0;
  logic        btn_rst = 1'b0;
  logic [23:0] t_in = 24'd0;
  logic        tick;
  logic        cnt_clr;
  logic [23:0] t_disp;
  logic [1:0]  state;
  logic        running;

  int tests = 0;
  int fails = 0;
  int t_mode = 0;

  stopwatch_ctrl #(.DIV(DIV)) dut (
    .clk     (clk),
    .clr     (clr),
    .btn_ss  (btn_ss),
    .btn_lap (btn_lap),
    .btn_rst (btn_rst),
    .t_in    (t_in),
    .tick    (tick),
    .cnt_clr (cnt_clr),
    .t_disp  (t_disp),
    .state   (state),
    .running (running)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a press is seen two samples after the rising level,
  // and the transition table below is the one in the state description.
  int          m_state = S_IDLE;
  int          m_phase = 0;
  bit          m_tick = 1'b0;
  bit          m_cclr = 1'b0;
  logic [23:0] m_disp = 24'd0;
  bit [2:0]    h_ss = 3'b000, h_lap = 3'b000, h_rst = 3'b000;
  bit          ev [3];
  int          m_next;
  bit          m_done;

  // ev: 0 = rst, 1 = ss, 2 = lap; returns -1 when the event is illegal
  function automatic int next_of(input int st, input int e);
    case (e)
      0: return (st == S_IDLE || st == S_PAUSE) ? S_IDLE : -1;
      1: return (st == S_RUN || st == S_LAP) ? S_PAUSE : S_RUN;
      default: begin
        if (st == S_RUN) return S_LAP;
        if (st == S_LAP) return S_RUN;
        return -1;
      end
    endcase
  endfunction

  function automatic bit is_running(input int st);
    return st == S_RUN || st == S_LAP;
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_state = S_IDLE;
      m_phase = 0;
      m_tick  = 1'b0;
      m_cclr  = 1'b0;
      m_disp  = 24'd0;
      h_ss    = 3'b000;
      h_lap   = 3'b000;
      h_rst   = 3'b000;
    end else begin
      ev[0] = h_rst[1] & ~h_rst[2];
      ev[1] = h_ss[1]  & ~h_ss[2];
      ev[2] = h_lap[1] & ~h_lap[2];
      m_next = m_state;
      m_done = 1'b0;
      m_cclr = 1'b0;
      for (int e = 0; e < 3; e++) begin
        if (!m_done && ev[e] && next_of(m_state, e) >= 0) begin
          m_next = next_of(m_state, e);
          m_done = 1'b1;
          m_cclr = (e == 0);
        end
      end
      m_tick = 1'b0;
      if (m_cclr) begin
        m_phase = 0;
      end else if (is_running(m_state) && is_running(m_next)) begin
        m_phase = (m_phase + 1) % DIV;
        m_tick  = (m_phase == 0);
      end
      if (m_state != S_LAP) m_disp = t_in;
      m_state = m_next;
      h_ss  = {h_ss[1:0], btn_ss};
      h_lap = {h_lap[1:0], btn_lap};
      h_rst = {h_rst[1:0], btn_rst};
    end
  end

  always @(negedge clk) begin
    checkOutput("state",   32'(state),   32'(m_state));
    checkOutput("tick",    32'(tick),    32'(m_tick));
    checkOutput("cnt_clr", 32'(cnt_clr), 32'(m_cclr));
    checkOutput("t_disp",  32'(t_disp),  32'(m_disp));
    checkOutput("running", 32'(running), 32'(is_running(m_state)));
  end

  // Drives buttons from the current negedge, then advances n cycles while
  // updating t_in per t_mode (0 hold, 1 ramp, 2 random).
  task automatic applyStimulus(input bit s, input bit l, input bit r, input int n);
    btn_ss  = s;
    btn_lap = l;
    btn_rst = r;
    repeat (n) begin
      @(negedge clk);
      case (t_mode)
        1: t_in = t_in + 24'd1;
        2: t_in = 24'($urandom);
        default: t_in = t_in;
      endcase
    end
  endtask

  task automatic press(input bit s, input bit l, input bit r, input int settle);
    applyStimulus(s, l, r, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, settle);
  endtask

  task automatic midCycleClear(input bit hold_ss);
    #2 clr = 1'b1;
    #1;
    checkOutput("clr_state",   32'(state),   32'd0);
    checkOutput("clr_tick",    32'(tick),    32'd0);
    checkOutput("clr_cnt_clr", 32'(cnt_clr), 32'd0);
    checkOutput("clr_t_disp",  32'(t_disp),  32'd0);
    btn_ss = hold_ss;
    @(negedge clk);
    #2 clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1 clr = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_state",  32'(state),  32'd0);
    checkOutput("reset_t_disp", 32'(t_disp), 32'd0);
    #2 clr = 1'b0;
    @(negedge clk);

    // Single-cycle ss press: RUN after the third edge
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("ss_not_yet", 32'(state), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("ss_to_run", 32'(state), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12);

    // Lap freeze with ramping time, then release
    t_mode = 0;
    t_in   = 24'h001234;
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 4);
    t_mode = 1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8);
    checkOutput("lap_state",  32'(state),  32'd3);
    checkOutput("lap_freeze", 32'(t_disp), 32'h001234);
    press(1'b0, 1'b1, 1'b0, 6);
    checkOutput("lap_release", 32'(state), 32'd1);

    // Pause / resume at assorted phases
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, k);
      press(1'b1, 1'b0, 1'b0, 10);
      press(1'b1, 1'b0, 1'b0, 9);
    end

    // rst in RUN ignored, then pause and zero
    press(1'b0, 1'b0, 1'b1, 6);
    checkOutput("rst_in_run", 32'(state), 32'd1);
    press(1'b1, 1'b0, 1'b0, 5);
    press(1'b0, 1'b1, 1'b0, 5);
    checkOutput("lap_in_pause", 32'(state), 32'd2);
    press(1'b0, 1'b0, 1'b1, 6);
    checkOutput("rst_in_pause", 32'(state), 32'd0);
    press(1'b0, 1'b1, 1'b0, 5);
    checkOutput("lap_in_idle", 32'(state), 32'd0);

    // All three together: in PAUSE rst wins, in RUN ss wins
    press(1'b1, 1'b0, 1'b0, 7);
    press(1'b1, 1'b0, 1'b0, 5);
    press(1'b1, 1'b1, 1'b1, 5);
    checkOutput("all_in_pause", 32'(state), 32'd0);
    press(1'b1, 1'b0, 1'b0, 6);
    press(1'b1, 1'b1, 1'b1, 5);
    checkOutput("all_in_run", 32'(state), 32'd2);

    // Mid-cycle clr in LAP with ss held through release
    press(1'b1, 1'b0, 1'b0, 5);
    press(1'b0, 1'b1, 1'b0, 5);
    midCycleClear(1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 4);
    checkOutput("held_ss_run", 32'(state), 32'd1);

    // Random traffic with occasional asynchronous clears
    t_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        midCycleClear(1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(($urandom_range(0, 5) == 0) ? ~btn_ss  : btn_ss,
                      ($urandom_range(0, 5) == 0) ? ~btn_lap : btn_lap,
                      ($urandom_range(0, 9) == 0) ? ~btn_rst : btn_rst, 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 1000000, giving clk cycles per count tick (legal range 2..2^20).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port clr, input, 1, the reset: asynchronous, active-high.
REQ-004 SHALL have port btn_ss, input, 1, start/stop button, asynchronous level.
REQ-005 SHALL have port btn_lap, input, 1, lap button, asynchronous level.
REQ-006 SHALL have port btn_rst, input, 1, zero-time button, asynchronous level.
REQ-007 SHALL have port t_in, input, 24, live BCD time from the stopwatch counter chain.
REQ-008 SHALL have port tick, output, 1, one-cycle count-enable pulse to the counter chain.
REQ-009 SHALL have port cnt_clr, output, 1, one-cycle synchronous clear pulse to the counter chain.
REQ-010 SHALL have port t_disp, output, 24, time value for the display.
REQ-011 SHALL have port state, output, 2, current FSM state encoding.
REQ-012 SHALL have port running, output, 1, high in RUN or LAP.

Function
REQ-013 SHALL pass each button through a 2-flop synchroniser and a rising-edge detector; one press gives one internal pulse, whatever the hold time.
REQ-014 SHALL update the state register on the 3rd rising clk edge after a button rises, given setup is met.
REQ-015 SHALL encode the states as IDLE=00, RUN=01, PAUSE=10, LAP=11.
REQ-016 In IDLE: ss goes to RUN; rst stays in IDLE and pulses cnt_clr; lap is ignored.
REQ-017 In RUN: ss goes to PAUSE; lap goes to LAP and freezes t_disp; rst is ignored.
REQ-018 In LAP: ss goes to PAUSE and t_disp resumes live; lap goes to RUN and t_disp resumes live; rst is ignored.
REQ-019 In PAUSE: ss goes to RUN; rst goes to IDLE and pulses cnt_clr; lap is ignored.
REQ-020 SHALL resolve presses detected in the same cycle by priority rst > ss > lap; only the highest legal event acts, the rest are dropped.
REQ-021 SHALL use a 20-bit prescaler that increments only in RUN or LAP; when it equals DIV-1 it asserts tick for that cycle and wraps to 0.
REQ-022 SHALL hold the prescaler value in PAUSE, so a resume keeps the tick phase.
REQ-023 SHALL clear the prescaler to 0 in the same cycle cnt_clr is asserted.
REQ-024 SHALL register tick and cnt_clr; tick is never asserted in IDLE or PAUSE.
REQ-025 SHALL drive cnt_clr high for exactly one cycle, the cycle after the state-register edge that accepted the rst press.
REQ-026 SHALL make t_disp a register that loads t_in every cycle in IDLE, RUN and PAUSE (1-cycle latency).
REQ-027 SHALL have t_disp hold the t_in value sampled on the RUN->LAP transition edge for as long as the FSM stays in LAP.
REQ-028 SHALL decode running combinationally from state.

Reset
REQ-029 SHALL, while clr=1, force state=IDLE, prescaler=0, tick=0, cnt_clr=0, t_disp=0 and all synchroniser/edge flops=0, independent of clk.
REQ-030 SHALL treat a button held high across clr deassertion as one press.
REQ-031 SHALL abort any LAP or RUN on mid-operation clr; after release, the block is in IDLE with no tick until ss.

Verification (DIV=4)
REQ-032 Reset, pulse btn_ss for 1 cycle: state=01 three edges later; tick pulses every 4th cycle, first pulse 4 cycles after entry to RUN.
REQ-033 From RUN with t_in=24'h001234, press btn_lap, then ramp t_in: t_disp stays 001234 and tick continues; press btn_lap again: t_disp tracks t_in with 1-cycle latency.
REQ-034 From RUN, press ss with prescaler=2, wait 10 cycles, press ss again: no tick in PAUSE; first tick after resume comes 1 count later (phase kept).
REQ-035 From PAUSE, press btn_rst: state=00, cnt_clr high for exactly 1 cycle, prescaler=0; btn_rst in RUN and btn_lap in IDLE/PAUSE have no effect.
REQ-036 Raise btn_rst, btn_ss and btn_lap in the same cycle, in PAUSE then in RUN: PAUSE goes to IDLE (rst wins); RUN goes to PAUSE (ss wins, rst illegal).
REQ-037 Assert clr asynchronously mid-cycle in LAP: outputs go to reset values before the next clk edge; holding btn_ss through release gives exactly one IDLE->RUN.
